// File: rtl/pool_window_former.sv
// Builds POOL_K-sample pooling windows at stride POOL_S from a per-channel activation stream
// and loads each channel's threshold first. Optional tail padding: define POOL_TAIL_PAD_EN.
module pool_window_former #(
    parameter int DW      = 9,
    parameter int POOL_K  = 7,
    parameter int POOL_S  = 7,
    parameter int SEQ_LEN = 128,
    parameter int THR_W   = 24,
    parameter int CH_AW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_AW-1:0]     ch_num,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic [CH_AW-1:0]     thr_addr,
    input  logic [THR_W-1:0]     thr_rdata,
    output logic [THR_W-1:0]     thr_out,
    output logic                 load_thr,
    output logic                 win_valid,
    output logic [DW*POOL_K-1:0] win_data,
    output logic                 win_last,
    output logic                 busy,
    output logic                 done
);
    localparam int WW       = DW * POOL_K;
    localparam int NWIN     = (SEQ_LEN - POOL_K) / POOL_S + 1;
    localparam int LAST_IDX = POOL_K - 1 + (NWIN - 1) * POOL_S;
    localparam int SCW      = $clog2(SEQ_LEN + 1);
    localparam int STW      = $clog2(POOL_S + 1);

`ifdef POOL_TAIL_PAD_EN
    localparam int REM    = (SEQ_LEN - POOL_K) % POOL_S;
    localparam int PAD_N  = (REM == 0) ? 0 : POOL_S - REM;
    localparam int PW     = $clog2(POOL_S + 1);
    localparam bit PAD_ON = (PAD_N != 0);
    typedef enum logic [2:0] {IDLE, THR_RD, THR_LD, STREAM, PAD, FIN} state_t;
`else
    localparam bit PAD_ON = 1'b0;
    typedef enum logic [2:0] {IDLE, THR_RD, THR_LD, STREAM, FIN} state_t;
`endif

    state_t           state_reg;
    logic [CH_AW-1:0] ch_reg, ch_last_reg;
    logic [SCW-1:0]   samp_cnt_reg;
    logic [STW-1:0]   str_cnt_reg;
    logic [WW-1:0]    sr_reg;
    logic             in_ready_reg, load_thr_reg, win_valid_reg, win_last_reg, busy_reg, done_reg;
    logic [CH_AW-1:0] thr_addr_reg;
    logic [THR_W-1:0] thr_out_reg;
    logic [WW-1:0]    win_data_reg;

    logic          accept, emit, at_end, chan_end;
    logic [WW-1:0] sr_shift;

    assign accept   = (state_reg == STREAM) && in_valid && in_ready_reg;
    assign sr_shift = {sr_reg[WW-DW-1:0], in_data};
    assign emit     = accept && (samp_cnt_reg >= SCW'(POOL_K - 1)) && (str_cnt_reg == '0);
    assign at_end   = accept && (samp_cnt_reg == SCW'(SEQ_LEN - 1));

`ifdef POOL_TAIL_PAD_EN
    logic [PW-1:0] pad_cnt_reg;
    logic [WW-1:0] pad_shift;
    logic          pad_done;
    // Filler is the most negative code so it can never beat a real sample in the max.
    assign pad_shift = {sr_reg[WW-DW-1:0], 1'b1, {(DW-1){1'b0}}};
    assign pad_done  = (state_reg == PAD) && (pad_cnt_reg == PW'(PAD_N - 1));
    assign chan_end  = (at_end && !PAD_ON) || pad_done;
`else
    assign chan_end  = at_end;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ch_reg        <= '0;
            ch_last_reg   <= '0;
            samp_cnt_reg  <= '0;
            str_cnt_reg   <= '0;
            sr_reg        <= '0;
            in_ready_reg  <= 1'b0;
            thr_addr_reg  <= '0;
            thr_out_reg   <= '0;
            load_thr_reg  <= 1'b0;
            win_valid_reg <= 1'b0;
            win_data_reg  <= '0;
            win_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef POOL_TAIL_PAD_EN
            pad_cnt_reg   <= '0;
`endif
        end else begin
            load_thr_reg  <= 1'b0;
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    state_reg    <= THR_RD;
                    ch_reg       <= '0;
                    thr_addr_reg <= '0;
                    ch_last_reg  <= (ch_num == '0) ? '0 : ch_num - 1'b1;
                    busy_reg     <= 1'b1;
                end
                THR_RD: state_reg <= THR_LD;
                // ROM data for thr_addr is present now; strobe and value appear together.
                THR_LD: begin
                    thr_out_reg  <= thr_rdata;
                    load_thr_reg <= 1'b1;
                    in_ready_reg <= 1'b1;
                    state_reg    <= STREAM;
                end
                STREAM: if (accept) begin
                    sr_reg       <= sr_shift;
                    samp_cnt_reg <= samp_cnt_reg + 1'b1;
                    if (samp_cnt_reg >= SCW'(POOL_K - 1))
                        str_cnt_reg <= (str_cnt_reg == STW'(POOL_S - 1)) ? '0 : str_cnt_reg + 1'b1;
                    if (emit) begin
                        win_valid_reg <= 1'b1;
                        win_data_reg  <= sr_shift;
                        win_last_reg  <= (samp_cnt_reg == SCW'(LAST_IDX)) && !PAD_ON;
                    end
                    if (at_end) begin
                        samp_cnt_reg <= '0;
                        str_cnt_reg  <= '0;
`ifdef POOL_TAIL_PAD_EN
                        // Keep the tail samples in the shift register for the padded window.
                        if (PAD_ON) begin
                            state_reg    <= PAD;
                            in_ready_reg <= 1'b0;
                        end else begin
                            sr_reg <= '0;
                        end
`else
                        sr_reg <= '0;
`endif
                    end
                end
`ifdef POOL_TAIL_PAD_EN
                PAD: begin
                    sr_reg      <= pad_shift;
                    pad_cnt_reg <= pad_cnt_reg + 1'b1;
                    if (pad_done) begin
                        win_valid_reg <= 1'b1;
                        win_data_reg  <= pad_shift;
                        win_last_reg  <= 1'b1;
                        pad_cnt_reg   <= '0;
                    end
                end
`endif
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase

            if (chan_end) begin
                in_ready_reg <= 1'b0;
                sr_reg       <= '0;
                if (ch_reg == ch_last_reg) begin
                    state_reg <= FIN;
                    done_reg  <= 1'b1;
                end else begin
                    ch_reg       <= ch_reg + 1'b1;
                    thr_addr_reg <= ch_reg + 1'b1;
                    state_reg    <= THR_RD;
                end
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign thr_addr  = thr_addr_reg;
    assign thr_out   = thr_out_reg;
    assign load_thr  = load_thr_reg;
    assign win_valid = win_valid_reg;
    assign win_data  = win_data_reg;
    assign win_last  = win_last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_pool_window_former.sv
// Scoreboard bench for pool_window_former: default geometry (A) and stride-1 short sequence (B).
module tb_pool_window_former;
    localparam int AK = 7, AS = 7, AL = 128;
    localparam int BK = 7, BS = 1, BL = 10;
    localparam int A_REM  = (AL - AK) % AS;
    localparam int A_PADN = (A_REM == 0) ? 0 : AS - A_REM;
`ifdef POOL_TAIL_PAD_EN
    localparam bit PAD_A = 1'b1;
`else
    localparam bit PAD_A = 1'b0;
`endif
    localparam int A_NWIN     = PAD_A ? 19 : 18;
    localparam int A_DONE_LAT = PAD_A ? A_PADN : 0;

    typedef struct packed {
        logic [62:0] data;
        logic        last;
        logic [31:0] due;
        logic [31:0] ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_in_valid = 0, a_in_ready, a_load_thr, a_win_valid, a_win_last, a_busy, a_done;
    logic [7:0]  a_ch_num = 0, a_thr_addr;
    logic [8:0]  a_in_data = 0;
    logic [23:0] a_thr_rdata = 0, a_thr_out;
    logic [62:0] a_win_data;
    logic        b_start = 0, b_in_valid = 0, b_in_ready, b_load_thr, b_win_valid, b_win_last, b_busy, b_done;
    logic [7:0]  b_ch_num = 0, b_thr_addr;
    logic [8:0]  b_in_data = 0;
    logic [23:0] b_thr_rdata = 0, b_thr_out;
    logic [62:0] b_win_data;

    pool_window_former dut_a (
        .clk(clk), .rst(rst), .start(a_start), .ch_num(a_ch_num),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .thr_addr(a_thr_addr), .thr_rdata(a_thr_rdata), .thr_out(a_thr_out), .load_thr(a_load_thr),
        .win_valid(a_win_valid), .win_data(a_win_data), .win_last(a_win_last),
        .busy(a_busy), .done(a_done)
    );

    pool_window_former #(.POOL_S(BS), .SEQ_LEN(BL)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .ch_num(b_ch_num),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .thr_addr(b_thr_addr), .thr_rdata(b_thr_rdata), .thr_out(b_thr_out), .load_thr(b_load_thr),
        .win_valid(b_win_valid), .win_data(b_win_data), .win_last(b_win_last),
        .busy(b_busy), .done(b_done)
    );

    // Threshold ROM with one cycle of read latency.
    logic [23:0] rom [4];
    always @(posedge clk) begin
        a_thr_rdata <= rom[a_thr_addr[1:0]];
        b_thr_rdata <= rom[b_thr_addr[1:0]];
    end

    int total = 0, bad = 0, cyc = 0;
    exp_t qa[$], qb[$];
    logic [8:0] a_hist [AL];
    logic [8:0] b_hist [BL];
    int a_j, a_ch_m, a_loads, a_wins, a_dones, a_load_cyc, a_done_cyc, a_acc_cyc, a_start_cyc;
    int b_j, b_loads, b_wins, b_dones;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        if (a_win_valid) begin
            a_wins++;
            if (qa.size() == 0) chk("a_spurious_win", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_win_data", a_win_data, e.data);
                chk("a_win_last", a_win_last, e.last);
                chk("a_win_cycle", cyc, e.due);
                chk("a_win_after_load", a_loads, e.ch + 1);
            end
        end
        if (a_load_thr) begin
            chk("a_thr_out", a_thr_out, rom[a_loads % 4]);
            a_loads++;
            a_load_cyc = cyc;
        end
        if (a_done) begin
            a_dones++;
            a_done_cyc = cyc;
        end
    endtask

    task automatic mon_b();
        exp_t e;
        if (b_win_valid) begin
            b_wins++;
            if (qb.size() == 0) chk("b_spurious_win", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_win_data", b_win_data, e.data);
                chk("b_win_last", b_win_last, e.last);
                chk("b_win_cycle", cyc, e.due);
            end
        end
        if (b_load_thr) begin
            chk("b_thr_out", b_thr_out, rom[0]);
            b_loads++;
        end
        if (b_done) b_dones++;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon_a();
        mon_b();
    endtask

    // Expected windows from the sample history: oldest sample lands in the MSBs.
    task automatic acc_a(input logic [8:0] v);
        exp_t e;
        a_hist[a_j] = v;
        if (a_j >= AK - 1 && (a_j - AK + 1) % AS == 0) begin
            e.data = '0;
            for (int i = a_j - AK + 1; i <= a_j; i++) e.data = {e.data[53:0], a_hist[i]};
            e.last = (a_j + AS > AL - 1) && !PAD_A;
            e.due  = cyc + 1;
            e.ch   = a_ch_m;
            qa.push_back(e);
        end
        if (a_j == AL - 1) begin
            if (PAD_A) begin
                e.data = '0;
                for (int i = AL - (AK - A_PADN); i < AL; i++) e.data = {e.data[53:0], a_hist[i]};
                for (int i = 0; i < A_PADN; i++) e.data = {e.data[53:0], 9'h100};
                e.last = 1'b1;
                e.due  = cyc + 1 + A_PADN;
                e.ch   = a_ch_m;
                qa.push_back(e);
            end
            a_j = 0;
            a_ch_m++;
        end else a_j++;
    endtask

    task automatic acc_b(input logic [8:0] v);
        exp_t e;
        b_hist[b_j] = v;
        if (b_j >= BK - 1 && (b_j - BK + 1) % BS == 0) begin
            e.data = '0;
            for (int i = b_j - BK + 1; i <= b_j; i++) e.data = {e.data[53:0], b_hist[i]};
            e.last = (b_j + BS > BL - 1);
            e.due  = cyc + 1;
            e.ch   = 0;
            qb.push_back(e);
        end
        b_j = (b_j == BL - 1) ? 0 : b_j + 1;
    endtask

    task automatic drive_a(input logic [8:0] v, input bit pulse_start);
        int budget = 0;
        a_in_valid = 1'b1;
        a_in_data  = v;
        while (!a_in_ready && budget < 40) begin step(); budget++; end
        if (budget >= 40) begin chk("a_ready_timeout", 0, 1); a_in_valid = 1'b0; return; end
        a_start = pulse_start;
        acc_a(v);
        step();
        a_start    = 1'b0;
        a_in_valid = 1'b0;
        a_acc_cyc  = cyc;
    endtask

    task automatic drive_b(input logic [8:0] v, input bit gap);
        int budget = 0;
        if (gap) begin b_in_valid = 1'b0; step(); end
        b_in_valid = 1'b1;
        b_in_data  = v;
        while (!b_in_ready && budget < 40) begin step(); budget++; end
        if (budget >= 40) begin chk("b_ready_timeout", 0, 1); b_in_valid = 1'b0; return; end
        acc_b(v);
        step();
        b_in_valid = 1'b0;
    endtask

    task automatic start_a(input logic [7:0] n);
        a_loads = 0; a_wins = 0; a_dones = 0; a_j = 0; a_ch_m = 0; a_done_cyc = -1;
        a_ch_num = n;
        a_start  = 1'b1;
        step();
        a_start     = 1'b0;
        a_start_cyc = cyc;
        chk("a_busy_after_start", a_busy, 1);
    endtask

    task automatic start_b(input logic [7:0] n);
        b_loads = 0; b_wins = 0; b_dones = 0; b_j = 0;
        b_ch_num = n;
        b_start  = 1'b1;
        step();
        b_start = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rom[0] = 24'h123456; rom[1] = 24'hABCDEF; rom[2] = 24'h0F0F0F; rom[3] = 24'h000001;
        idle_steps(3);
        chk("rst_a_flags", {a_in_ready, a_win_valid, a_win_last, a_load_thr, a_busy, a_done}, 6'b0);
        chk("rst_a_data", {a_win_data, a_thr_out, a_thr_addr}, 0);
        chk("rst_b_flags", {b_in_ready, b_win_valid, b_win_last, b_load_thr, b_busy, b_done}, 6'b0);
        rst = 1'b0;
        step();

        // Single channel, ramp data, back-to-back; a start pulse mid-stream must be ignored.
        start_a(8'd1);
        for (int i = 0; i < AL; i++) drive_a(9'(i % 256), i == 50);
        idle_steps(A_DONE_LAT + 6);
        chk("s1_load_latency", a_load_cyc - a_start_cyc, 2);
        chk("s1_loads", a_loads, 1);
        chk("s1_windows", a_wins, A_NWIN);
        chk("s1_queue_empty", qa.size(), 0);
        chk("s1_dones", a_dones, 1);
        chk("s1_done_latency", a_done_cyc - a_acc_cyc, A_DONE_LAT);
        chk("s1_idle_busy", a_busy, 0);

        // Three channels with edge-case thresholds; channel 0 carries negative data.
        rom[0] = 24'h800801; rom[1] = 24'h000000; rom[2] = 24'hFFFFFF;
        start_a(8'd3);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < AL; i++) begin
                if (c == 0) drive_a(9'(i - 256), 1'b0);
                else if (c == 1) drive_a(9'($urandom), 1'b0);
                else drive_a(9'(i * 5), 1'b0);
                if (c == 0 && i == AK - 1) begin
                    chk("s2_neg_valid", a_win_valid, 1);
                    chk("s2_neg_msb", a_win_data[62:54], 9'h100);
                end
            end
        end
        idle_steps(A_DONE_LAT + 6);
        chk("s2_loads", a_loads, 3);
        chk("s2_windows", a_wins, 3 * A_NWIN);
        chk("s2_queue_empty", qa.size(), 0);
        chk("s2_dones", a_dones, 1);

        // Reset after the fifth window of channel 0, then a fresh layer.
        rom[0] = 24'h5A5A5A;
        start_a(8'd2);
        for (int i = 0; i < 35; i++) drive_a(9'(i), 1'b0);
        chk("s3_five_windows", a_wins, 5);
        rst = 1'b1;
        step();
        chk("s3_rst_flags", {a_in_ready, a_win_valid, a_win_last, a_load_thr, a_busy, a_done}, 6'b0);
        chk("s3_rst_data", {a_win_data, a_thr_out, a_thr_addr}, 0);
        rst = 1'b0;
        qa.delete();
        a_dones = 0;
        idle_steps(4);
        chk("s3_no_done", a_dones, 0);
        start_a(8'd1);
        for (int i = 0; i < AL; i++) drive_a(9'(255 - i), 1'b0);
        idle_steps(A_DONE_LAT + 6);
        chk("s3_loads", a_loads, 1);
        chk("s3_windows", a_wins, A_NWIN);
        chk("s3_dones", a_dones, 1);

        // Stride 1, short sequence: gap-free, then with in_valid toggling and ch_num=0.
        rom[0] = 24'h00C0DE;
        start_b(8'd1);
        for (int i = 0; i < BL; i++) drive_b(9'(i * 3 + 1), 1'b0);
        idle_steps(4);
        chk("b_windows", b_wins, 4);
        chk("b_dones", b_dones, 1);
        start_b(8'd0);
        for (int i = 0; i < BL; i++) drive_b(9'(i * 3 + 1), 1'b1);
        idle_steps(4);
        chk("b_gap_windows", b_wins, 4);
        chk("b_gap_loads", b_loads, 1);
        chk("b_gap_dones", b_dones, 1);
        chk("b_queue_empty", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
